// File: rtl/bsh_pkg.sv
// Shared constants and state encoding for the shared barrel-shifter scheduler.
package bsh_pkg;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned SH_W   = 5;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      HOLD
   } state_t;
endpackage

// File: rtl/bsh_32.sv
// 32-bit combinational logical barrel shifter, zero fill in both directions.
module bsh_32
   import bsh_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   input  logic              dir,
   input  logic [SH_W-1:0]   sh,
   output logic [DATA_W-1:0] result
);

   assign result = (dir == DIR_RIGHT) ? (data >> sh) : (data << sh);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, modulo N_REQ.
module rr_arbiter #(
   parameter  int unsigned N_REQ = 4,
   localparam int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_idx
);

   always_comb begin
      int unsigned k;
      logic        found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      k         = 0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         k = 32'(ptr) + i;
         if (k >= N_REQ) k = k - N_REQ;
         if (!found && req[k[ID_W-1:0]]) begin
            found                 = 1'b1;
            grant[k[ID_W-1:0]]    = 1'b1;
            grant_idx             = k[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/bsh_rr_sched.sv
// Round-robin scheduler sharing one bsh_32 among N_REQ requesters; results
// return on a valid/ready port tagged with the requester index.
module bsh_rr_sched
   import bsh_pkg::*;
#(
   parameter  int unsigned N_REQ  = 4,
   parameter  int unsigned DATA_W = 32,
   localparam int unsigned ID_W   = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   input  logic [N_REQ-1:0]        req_dir,
   input  logic [N_REQ*SH_W-1:0]   req_sh,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_W-1:0]       rsp_data,
   output logic [ID_W-1:0]         rsp_id,
   output logic                    busy
);

   state_t              state, state_nx;
   logic [ID_W-1:0]     ptr;
   logic [ID_W-1:0]     g_idx;
   logic [N_REQ-1:0]    g_onehot;
   logic                accept_ok;
   logic                accept;
   logic [DATA_W-1:0]   op_data;
   logic                op_dir;
   logic [SH_W-1:0]     op_sh;
   logic [ID_W-1:0]     op_id;
   logic [DATA_W-1:0]   sh_out;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req       (req_valid),
      .ptr       (ptr),
      .grant     (g_onehot),
      .grant_idx (g_idx)
   );

   bsh_32 u_bsh (
      .data   (op_data),
      .dir    (op_dir),
      .sh     (op_sh),
      .result (sh_out)
   );

   // HOLD can hand off to a new op in the same cycle the response drains.
   assign accept_ok = (state == IDLE) | ((state == HOLD) & rsp_ready);
   assign accept    = accept_ok & (|req_valid);
   // Gated by rst_n so no requester sees a grant while reset is asserted.
   assign req_ready = (rst_n && accept_ok) ? g_onehot : '0;
   assign rsp_valid = (state == HOLD);
   assign busy      = (state != IDLE);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = SHIFT;
         SHIFT:   state_nx = HOLD;
         HOLD:    if (rsp_ready) state_nx = accept ? SHIFT : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         op_data  <= '0;
         op_dir   <= 1'b0;
         op_sh    <= '0;
         op_id    <= '0;
         rsp_data <= '0;
         rsp_id   <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_data <= req_data[32'(g_idx)*DATA_W +: DATA_W];
            op_dir  <= req_dir[g_idx];
            op_sh   <= req_sh[32'(g_idx)*SH_W +: SH_W];
            op_id   <= g_idx;
            ptr     <= (g_idx == ID_W'(N_REQ-1)) ? '0 : g_idx + ID_W'(1);
         end
         if (state == SHIFT) begin
            rsp_data <= sh_out;
            rsp_id   <= op_id;
         end
      end
   end

endmodule

// File: tb/tb_bsh_rr_sched.sv
// Self-checking bench: directed cases plus randomized traffic against a behavioural model.
module tb_bsh_rr_sched;
   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [N*32-1:0] req_data;
   logic [N-1:0]  req_dir;
   logic [N*5-1:0] req_sh;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_data;
   logic [1:0]    rsp_id;
   logic          busy;

   always #5 clk = ~clk;

   bsh_rr_sched #(.N_REQ(4), .DATA_W(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_dir   (req_dir),
      .req_sh    (req_sh),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   int m_ptr = 0;
   bit m_has = 0;
   bit m_ready = 0;
   logic [31:0] m_data = '0;
   int m_id = 0;
   int m_acc = -1;
   bit refill = 0;
   int dut_acc = 0;
   int seen_ids[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] golden(input logic [31:0] d, input logic dir, input int sh);
      return dir ? (d >> sh) : (d << sh);
   endfunction

   // Model: at most one op in flight; its result becomes visible one edge after
   // acceptance and leaves on the first cycle rsp_ready is seen high.
   always @(negedge clk) begin
      int g;
      int k;
      bit ok;
      logic [N-1:0] exp_rdy;
      if (!rst_n) begin
         m_has = 0; m_ready = 0; m_ptr = 0; m_acc = -1;
         chk("rst_req_ready", 32'(req_ready), 32'(0));
         chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
         chk("rst_busy", 32'(busy), 32'(0));
      end else begin
         ok = !m_has || (m_ready && rsp_ready);
         g = -1;
         for (int j = 0; j < N; j++) begin
            k = (m_ptr + j) % N;
            if (g < 0 && req_valid[k]) g = k;
         end
         exp_rdy = '0;
         if (ok && g >= 0) exp_rdy[g] = 1'b1;
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_has && m_ready));
         chk("busy", 32'(busy), 32'(m_has));
         if (m_has && m_ready) begin
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
         end
         if (rsp_valid && rsp_ready) seen_ids.push_back(int'(rsp_id));
         if (|(req_valid & req_ready)) dut_acc++;
         if (m_has && !m_ready) m_ready = 1;
         else if (m_has && rsp_ready) m_has = 0;
         m_acc = -1;
         if (ok && g >= 0) begin
            m_has = 1; m_ready = 0;
            m_data = golden(req_data[32*g +: 32], req_dir[g], int'(req_sh[5*g +: 5]));
            m_id = g;
            m_ptr = (g + 1) % N;
            m_acc = g;
         end
      end
   end

   task automatic set_req(input int i, input logic [31:0] d, input logic dir, input logic [4:0] sh);
      req_data[32*i +: 32] = d;
      req_dir[i]           = dir;
      req_sh[5*i +: 5]     = sh;
      req_valid[i]         = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (m_acc >= 0) begin
         if (refill) set_req(m_acc, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
         else req_valid[m_acc] = 1'b0;
      end
   endtask

   task automatic run_one(input int i, input logic [31:0] d, input logic dir,
                          input logic [4:0] sh, input logic [31:0] exp);
      set_req(i, d, dir, sh);
      tick();
      tick();
      chk("one_data", rsp_data, exp);
      chk("one_id", 32'(rsp_id), 32'(i));
      tick();
      chk("one_busy_done", 32'(busy), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid = '0; req_data = '0; req_dir = '0; req_sh = '0; rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rsp_data", rsp_data, 32'h0);
      chk("reset_rsp_id", 32'(rsp_id), 32'(0));
      chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("reset_busy", 32'(busy), 32'(0));
      req_valid = '1;
      #1;
      chk("reset_req_ready_forced", 32'(req_ready), 32'(0));
      req_valid = '0;
      rst_n = 1'b1;

      // Single op, left
      rsp_ready = 1'b1;
      set_req(0, 32'h0000_00F0, 1'b0, 5'd4);
      tick();
      chk("t1_busy", 32'(busy), 32'(1));
      chk("t1_no_rsp_yet", 32'(rsp_valid), 32'(0));
      tick();
      chk("t1_rsp_valid", 32'(rsp_valid), 32'(1));
      chk("t1_rsp_data", rsp_data, 32'h0000_0F00);
      chk("t1_rsp_id", 32'(rsp_id), 32'(0));
      tick();
      chk("t1_idle", 32'(busy), 32'(0));

      // Boundaries from requester 2
      run_one(2, 32'h8000_0000, 1'b1, 5'd31, 32'h0000_0001);
      run_one(2, 32'hDEAD_BEEF, 1'b1, 5'd0,  32'hDEAD_BEEF);
      run_one(2, 32'hFFFF_FFFF, 1'b0, 5'd31, 32'h8000_0000);

      // Pointer wrap and skip: ptr is 3
      set_req(3, 32'h0000_0001, 1'b0, 5'd1);
      set_req(1, 32'h0000_0010, 1'b1, 5'd4);
      #1;
      chk("wrap_grant3", 32'(req_ready), 32'h8);
      tick();
      tick();
      chk("wrap_id3", 32'(rsp_id), 32'(3));
      chk("wrap_data3", rsp_data, 32'h2);
      chk("wrap_grant1", 32'(req_ready), 32'h2);
      tick();
      chk("wrap_shift", 32'(rsp_valid), 32'(0));
      tick();
      chk("wrap_id1", 32'(rsp_id), 32'(1));
      chk("wrap_data1", rsp_data, 32'h1);
      tick();

      // Backpressure: ptr is 2, requesters 1 and 2 pending
      rsp_ready = 1'b0;
      set_req(2, 32'h1234_5678, 1'b0, 5'd8);
      set_req(1, 32'h0000_FF00, 1'b1, 5'd8);
      #1;
      chk("bp_grant2", 32'(req_ready), 32'h4);
      tick();
      tick();
      for (int c = 0; c < 5; c++) begin
         chk("bp_hold_data", rsp_data, 32'h3456_7800);
         chk("bp_hold_id", 32'(rsp_id), 32'(2));
         chk("bp_hold_ready", 32'(req_ready), 32'(0));
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_grant", 32'(req_ready), 32'h2);
      tick();
      chk("bp_next_shift", 32'(rsp_valid), 32'(0));
      chk("bp_next_busy", 32'(busy), 32'(1));
      tick();
      chk("bp_next_data", rsp_data, 32'h0000_00FF);
      chk("bp_next_id", 32'(rsp_id), 32'(1));
      tick();

      // Reset while in SHIFT
      set_req(3, 32'hA5A5_A5A5, 1'b0, 5'd1);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(rsp_valid), 32'(0));
      chk("rst_mid_ready", 32'(req_ready), 32'(0));
      chk("rst_mid_busy", 32'(busy), 32'(0));
      req_valid = '1;
      #1;
      chk("rst_mid_ready_all", 32'(req_ready), 32'(0));
      req_valid = '0;
      tick();
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      chk("rst_no_stray", 32'(rsp_valid), 32'(0));

      // Fairness: all requesters continuously valid, ptr back at 0
      refill = 1;
      for (int i = 0; i < N; i++)
         set_req(i, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      #1;
      chk("fair_first_grant", 32'(req_ready), 32'h1);
      seen_ids.delete();
      dut_acc = 0;
      repeat (20) tick();
      chk("fair_accept_rate", 32'(dut_acc), 32'(10));
      refill = 0;
      repeat (12) tick();
      chk("fair_count", 32'(seen_ids.size() >= 8), 32'(1));
      for (int k = 0; k < 8; k++)
         if (k < seen_ids.size()) chk("fair_order", 32'(seen_ids[k]), 32'(k % 4));

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         tick();
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && $urandom_range(0, 1) == 1)
               set_req(i, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      rsp_ready = 1'b1;
      repeat (20) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bsh_rr_sched.md
Name: bsh_rr_sched

Overview:
Round-robin scheduler that shares one combinational bsh_32 barrel shifter among N_REQ requesters. Each requester presents a shift operation with a valid/ready handshake. The block grants one requester, registers its operands, drives them through the shifter, and returns the registered result tagged with the requester ID on a valid/ready response port. It sits between the shift-issuing clients and the single shifter instance.

Parameters:
N_REQ, 4, number of requesters (>=2); ID_W = $clog2(N_REQ) is a derived localparam.
DATA_W, 32, operand width; fixed at 32 to match bsh_32.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester operation valid
req_ready  out  N_REQ  per-requester accept; at most one bit high
req_data  in  N_REQ*32  operand, requester i in bits [32*i+31:32*i]
req_dir  in  N_REQ  direction: 0 = logical left, 1 = logical right
req_sh  in  N_REQ*5  shift amount 0..31, requester i in bits [5*i+4:5*i]
rsp_valid  out  1  result valid
rsp_ready  in  1  result consumer ready
rsp_data  out  32  shifted result
rsp_id  out  ID_W  index of the requester that produced rsp_data
busy  out  1  high when state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0, operand registers=0.
  - req_ready forced to all-0 while rst_n=0.
  - An in-flight operation is dropped and never returns a response.
- FSM states:
  - IDLE: no operation held.
  - SHIFT: operands are registered and the shifter output is settling.
  - HOLD: result is registered and rsp_valid=1.
- accept_ok = (state==IDLE) | (state==HOLD & rsp_ready). This is a combinational path from rsp_ready to req_ready.
- Arbitration:
  - g = first index with req_valid set, searching ptr, ptr+1, ... mod N_REQ.
  - req_ready[g] = accept_ok & req_valid[g]. All other req_ready bits are 0.
- Accept edge (req_valid[g] & req_ready[g]):
  - Latch data/dir/sh/id of requester g.
  - ptr <= (g+1) mod N_REQ, wrapping N_REQ-1 -> 0.
  - state <= SHIFT.
- ptr changes only on an accept edge. Requests that are idle or not granted leave ptr unchanged.
- SHIFT -> HOLD is unconditional on the next edge:
  - rsp_data <= bsh_32(op_data, op_dir, op_sh).
  - rsp_id <= op_id.
  - rsp_valid <= 1.
- HOLD:
  - rsp_data and rsp_id stay stable until rsp_valid & rsp_ready.
  - On handshake with a new accept in the same cycle: state <= SHIFT and rsp_valid <= 0.
  - On handshake without a new accept: state <= IDLE and rsp_valid <= 0.
- Latency: accept at edge E0, rsp_valid high after edge E1. Peak throughput is one operation per 2 cycles.
- Shifter semantics:
  - Logical shift, zero fill.
  - sh=0 passes the operand unchanged.
  - sh=31 with dir=1 leaves only the old bit 31, now at bit 0.
- Requester rules:
  - Once asserted, req_valid and the operands must stay stable until ready.
  - req_valid must not depend on req_ready.
  - The scheduler does not check these rules.
- Simultaneous events: several valid requesters are resolved by ptr order only. Fixed priority is never used.

Decomposition:
- Package bsh_pkg:
  - constants DATA_W=32 and SH_W=5
  - dir encodings DIR_LEFT=0 and DIR_RIGHT=1
  - state enum {IDLE, SHIFT, HOLD}
- Sub-module rr_arbiter (parameter N_REQ):
  - inputs: req vector, ptr
  - outputs: one-hot grant and encoded grant index
  - purely combinational, reusable
- bsh_32 is instantiated unchanged as the datapath. The scheduler contains the FSM, ptr, operand registers and response registers.

Test Plan:
- Single op, left: req0 sends data=0x000000F0, dir=0, sh=4; rsp_ready=1 -> rsp_valid one cycle after the accept edge, rsp_data=0x00000F00, rsp_id=0, busy back to 0 after the handshake.
- Right and boundary cases: req2 sends 0x80000000, dir=1, sh=31 -> 0x00000001. Then 0xDEADBEEF, sh=0 -> 0xDEADBEEF. Then 0xFFFFFFFF, dir=0, sh=31 -> 0x80000000.
- Fairness: all four req_valid held high, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1,... with a new accept every 2 cycles. Each rsp_data matches the golden shift of its own operands.
- Backpressure: rsp_ready=0 for 5 cycles while in HOLD -> rsp_data and rsp_id stable, req_ready=0. Raising rsp_ready completes the response and accepts the next granted request in the same cycle.
- Pointer wrap and skip: only req3 and req1 valid, ptr=3 -> grant 3, ptr becomes 0, then grant 1, ptr becomes 2.
- Reset mid-op: deassert rst_n asynchronously while in SHIFT -> rsp_valid=0 and req_ready=0 immediately. After release, state=IDLE, ptr=0, and no stray response ever appears.
